// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit seven-segment display multiplexer.
package display_pkg;

    typedef enum logic [1:0] {
        BLANK0,
        SHOW0,
        BLANK1,
        SHOW1
    } mux_state_t;

    localparam int unsigned REFRESH_DIV_DEF  = 24_000;
    localparam int unsigned BLANK_CYCLES_DEF = 120;

    // Anode enables are active-low (PNP drivers).
    localparam logic [1:0] AN_OFF = 2'b11;
    localparam logic [1:0] AN_D0  = 2'b10;
    localparam logic [1:0] AN_D1  = 2'b01;

    // Dwell counter width: enough bits to hold max(a, b) - 1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs (DIP switches); both stages clear on reset.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/display_mux.sv
// Time-multiplexes two synchronized switch nibbles onto the shared seven-segment decoder,
// with a dark blanking interval before each digit is lit to avoid ghosting.
module display_mux
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = REFRESH_DIV_DEF,
    parameter int unsigned BLANK_CYCLES = BLANK_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    output logic [3:0] num,
    output logic [1:0] an,
    output logic       digit
);

    localparam int unsigned CNT_W = cnt_width(REFRESH_DIV, BLANK_CYCLES);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    logic [3:0] s0_sync;
    logic [3:0] s1_sync;

    sync_2ff #(
        .WIDTH (4)
    ) u_sync_s0 (
        .clk   (clk),
        .reset (reset),
        .d     (s0),
        .q     (s0_sync)
    );

    sync_2ff #(
        .WIDTH (4)
    ) u_sync_s1 (
        .clk   (clk),
        .reset (reset),
        .d     (s1),
        .q     (s1_sync)
    );

    mux_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       num_q, num_d;
    logic [1:0]       an_q, an_d;
    logic             is_show;
    logic             dwell_done;

    always_comb begin
        is_show    = (state_q == SHOW0) || (state_q == SHOW1);
        dwell_done = is_show ? (cnt_q == SHOW_LAST) : (cnt_q == BLANK_LAST);

        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        if (dwell_done) begin
            cnt_d = '0;
            unique case (state_q)
                BLANK0:  state_d = SHOW0;
                SHOW0:   state_d = BLANK1;
                BLANK1:  state_d = SHOW1;
                default: state_d = BLANK0;
            endcase
        end

        // Loading only while dark keeps num frozen for the whole time an anode is on.
        num_d = num_q;
        unique case (state_q)
            BLANK0:  num_d = s0_sync;
            BLANK1:  num_d = s1_sync;
            default: num_d = num_q;
        endcase

        // Decoded from the next state so the anodes switch on the same edge as the FSM.
        unique case (state_d)
            SHOW0:   an_d = AN_D0;
            SHOW1:   an_d = AN_D1;
            default: an_d = AN_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BLANK0;
            cnt_q   <= '0;
            num_q   <= '0;
            an_q    <= AN_OFF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            an_q    <= an_d;
        end
    end

    assign num   = num_q;
    assign an    = an_q;
    assign digit = (state_q == BLANK1) || (state_q == SHOW1);

endmodule
